alu_pipe: RTL and testbench
===========================

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter N, default 8, meaning operand/result width; legal values are powers of two from 4 to 64.
REQ-002 Parameter S, default $clog2(N), meaning shift-amount width; S is derived from N and is never overridden.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operand beat present.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 a, b  input  N each  operands.
REQ-008 opcode  input  4  operation select, encoded per REQ-016.
REQ-009 out_valid  output  1  result beat present.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 out  output  N  result.
REQ-012 flags  output  8  {lt, gt, eq, parity, sign, overflow, carry, zero}, with zero at bit 0.
REQ-013 sticky_ovf  output  1  set by any accepted result with overflow=1.
REQ-014 clr_sticky  input  1  synchronous clear of sticky_ovf.

Function
REQ-015 The block SHALL be a 2-stage pipeline:
- S1 registers a, b and opcode when in_valid && in_ready.
- S2 computes the result and registers out and flags.
- Latency: 2 cycles from accept to out_valid with no backpressure.
REQ-016 Opcodes SHALL be:
- 0 ADD, 1 SUB, 2 NAND, 3 NOR, 4 AND, 5 OR, 6 XOR, 7 NOT(~a).
- 8 SHL, 9 SHR, A ROL, B ROR, C SRA; shift amount is b[S-1:0].
- D SLT (signed a<b gives 1, else 0), E SLTU (unsigned), F NOP (out=a).
REQ-017 ADD carry SHALL be bit N of the (N+1)-bit sum; SUB carry SHALL be the borrow, i.e. 1 when a<b unsigned; carry=0 for all other ops.
REQ-018 overflow SHALL be signed two's-complement overflow for ADD/SUB only, and 0 otherwise.
REQ-019 Result-derived flags:
- zero = (out==0).
- sign = out[N-1].
- parity = XOR-reduce of out.
REQ-020 Operand-derived flags, for every op:
- eq = (a==b).
- gt = a>b unsigned.
- lt = a<b unsigned.
REQ-021 Handshake:
- S2 advances when !out_valid || out_ready.
- S1 advances when S1 is empty or S2 advances.
- in_ready = !s1_valid || s2_advance (combinational, no dependency on in_valid).
REQ-022 out, flags and out_valid SHALL hold stable while out_valid && !out_ready.
REQ-023 Beats SHALL never be dropped, duplicated or reordered; full throughput is one beat per cycle while out_ready=1.
REQ-024 Simultaneous S2 drain and S1 fill in one cycle SHALL be supported without a bubble.
REQ-025 sticky_ovf:
- Set on the S2 load of a beat with overflow=1.
- When clr_sticky and a set event occur in the same cycle, set wins.
REQ-026 Shift amounts SHALL wrap modulo N by construction; rotate by 0 returns a.

Reset
REQ-027 While rst_n=0:
- s1_valid=0, out_valid=0, out=0, flags=0, sticky_ovf=0.
- in_ready=1 from the first cycle after release.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight beats; no out_valid SHALL appear for them after release.

Verification (N=8)
REQ-029 Basic ADD: a=0x0A, b=0x05, op=0, single beat, out_ready=1 -> 2 cycles later out=0x0F, flags zero=carry=overflow=0, gt=1.
REQ-030 ADD/SUB edge values: a=0x72, b=0x93.
- ADD -> out=0x05, carry=1, overflow=0, lt=1.
- SUB -> out=0xDF, carry=1, overflow=1, sign=1, sticky_ovf=1 afterwards.
REQ-031 Shifts and compares: a=0xB2, b=0x03.
- SRA -> 0xF6.
- ROL -> 0x95.
- ROR -> 0x56.
- SHR -> 0x16.
- SLT -> 0x01.
- SLTU -> 0x00.
REQ-032 Backpressure: stream the 16 opcodes back-to-back, out_ready low for 3 cycles mid-stream.
- in_ready falls within 2 cycles of the stall.
- out holds stable during the stall.
- All 16 results arrive in order with none lost.
REQ-033 Reset mid-operation: assert rst_n=0 with 2 beats in flight -> out_valid=0 and out=0 immediately; no stale beat after release; next beat has 2-cycle latency.
REQ-034 Sticky clear: clr_sticky pulsed in the same cycle as an overflowing SUB load -> sticky_ovf stays 1; a later clr_sticky alone clears it.

Source files
------------

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - two-stage ALU pipeline with valid/ready handshake and sticky overflow
module alu_pipe #(
    parameter int N = 8,
    parameter int S = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   opcode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out,
    output logic [7:0]   flags,
    output logic         sticky_ovf,
    input  logic         clr_sticky
);

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_NAND = 4'h2;
    localparam logic [3:0] OP_NOR  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_NOT  = 4'h7;
    localparam logic [3:0] OP_SHL  = 4'h8;
    localparam logic [3:0] OP_SHR  = 4'h9;
    localparam logic [3:0] OP_ROL  = 4'hA;
    localparam logic [3:0] OP_ROR  = 4'hB;
    localparam logic [3:0] OP_SRA  = 4'hC;
    localparam logic [3:0] OP_SLT  = 4'hD;
    localparam logic [3:0] OP_SLTU = 4'hE;

    // N is a power of two, so N itself needs one bit more than a shift amount
    localparam logic [S:0] N_W = (S+1)'(N);

    logic         s1_valid_q, s1_valid_d;
    logic [N-1:0] a_q, a_d;
    logic [N-1:0] b_q, b_d;
    logic [3:0]   op_q, op_d;

    logic         out_valid_q, out_valid_d;
    logic [N-1:0] out_q, out_d;
    logic [7:0]   flags_q, flags_d;
    logic         sticky_q, sticky_d;

    logic         s2_advance;
    logic         s1_advance;

    logic [N-1:0] res;
    logic         carry;
    logic         ovf;
    logic [N:0]   sum;
    logic [N:0]   diff;
    logic [S-1:0] sh;
    logic [S:0]   rsh;

    assign s2_advance = !out_valid_q || out_ready;
    assign s1_advance = !s1_valid_q || s2_advance;
    assign in_ready   = s1_advance;

    assign out_valid  = out_valid_q;
    assign out        = out_q;
    assign flags      = flags_q;
    assign sticky_ovf = sticky_q;

    // Stage 1: capture operands whenever the stage can take a new beat
    always_comb begin
        s1_valid_d = s1_valid_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        if (s1_advance) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                a_d  = a;
                b_d  = b;
                op_d = opcode;
            end
        end
    end

    // ALU datapath on stage-1 operands; rotates use a complementary shift of N-sh, which is N (yielding 0) when sh=0
    always_comb begin
        sum   = {1'b0, a_q} + {1'b0, b_q};
        diff  = {1'b0, a_q} - {1'b0, b_q};
        sh    = b_q[S-1:0];
        rsh   = N_W - {1'b0, sh};
        res   = a_q;
        carry = 1'b0;
        ovf   = 1'b0;
        case (op_q)
            OP_ADD: begin
                res   = sum[N-1:0];
                carry = sum[N];
                ovf   = (a_q[N-1] == b_q[N-1]) && (sum[N-1] != a_q[N-1]);
            end
            OP_SUB: begin
                res   = diff[N-1:0];
                carry = diff[N];
                ovf   = (a_q[N-1] != b_q[N-1]) && (diff[N-1] != a_q[N-1]);
            end
            OP_NAND: res = ~(a_q & b_q);
            OP_NOR:  res = ~(a_q | b_q);
            OP_AND:  res = a_q & b_q;
            OP_OR:   res = a_q | b_q;
            OP_XOR:  res = a_q ^ b_q;
            OP_NOT:  res = ~a_q;
            OP_SHL:  res = a_q << sh;
            OP_SHR:  res = a_q >> sh;
            OP_ROL:  res = (a_q << sh) | (a_q >> rsh);
            OP_ROR:  res = (a_q >> sh) | (a_q << rsh);
            OP_SRA:  res = $signed(a_q) >>> sh;
            OP_SLT:  res = {{(N-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            OP_SLTU: res = {{(N-1){1'b0}}, (a_q < b_q)};
            default: res = a_q;
        endcase
    end

    // Stage 2: load result and flags when the consumer side can move; hold otherwise
    always_comb begin
        out_valid_d = out_valid_q;
        out_d       = out_q;
        flags_d     = flags_q;
        if (s2_advance) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_d   = res;
                flags_d = {(a_q < b_q), (a_q > b_q), (a_q == b_q), ^res,
                           res[N-1], ovf, carry, (res == '0)};
            end
        end
    end

    // Sticky overflow: a clear request loses to a same-cycle overflowing load
    always_comb begin
        sticky_d = clr_sticky ? 1'b0 : sticky_q;
        if (s2_advance && s1_valid_q && ovf) begin
            sticky_d = 1'b1;
        end
    end

    // State registers; reset discards any in-flight beats
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            flags_q     <= '0;
            sticky_q    <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            flags_q     <= flags_d;
            sticky_q    <= sticky_d;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - directed self-checking bench for alu_pipe
module tb_alu_pipe;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] opcode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out;
    logic [7:0] flags;
    logic       sticky_ovf;
    logic       clr_sticky;

    int n_cmp;
    int n_fail;

    alu_pipe #(.N(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .opcode     (opcode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out        (out),
        .flags      (flags),
        .sticky_ovf (sticky_ovf),
        .clr_sticky (clr_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single beat into an empty pipe; returns out_valid after one edge and the result after two
    task automatic run_beat(input logic [7:0] ta, input logic [7:0] tb, input logic [3:0] top,
                            output logic early, output logic ov,
                            output logic [7:0] o, output logic [7:0] f);
        @(negedge clk);
        a = ta; b = tb; opcode = top; in_valid = 1'b1;
        @(posedge clk); #1;
        early = out_valid;
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        ov = out_valid; o = out; f = flags;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_cmp++; if (out !== 8'h00) begin n_fail++; $display("FAIL reset_out: got %h expected 00", out); end
        n_cmp++; if (flags !== 8'h00) begin n_fail++; $display("FAIL reset_flags: got %h expected 00", flags); end
        n_cmp++; if (sticky_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_sticky: got %b expected 0", sticky_ovf); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_basic_add();
        logic early, ov;
        logic [7:0] o, f;
        run_beat(8'h0A, 8'h05, 4'h0, early, ov, o, f);
        n_cmp++; if (early !== 1'b0) begin n_fail++; $display("FAIL add_latency_early: got %b expected 0", early); end
        n_cmp++; if (ov !== 1'b1) begin n_fail++; $display("FAIL add_out_valid: got %b expected 1", ov); end
        n_cmp++; if (o !== 8'h0F) begin n_fail++; $display("FAIL add_out: got %h expected 0f", o); end
        n_cmp++; if (f !== 8'h40) begin n_fail++; $display("FAIL add_flags: got %h expected 40", f); end
    endtask

    task automatic test_add_sub_edge();
        logic early, ov;
        logic [7:0] o, f;
        run_beat(8'h72, 8'h93, 4'h0, early, ov, o, f);
        n_cmp++; if (o !== 8'h05) begin n_fail++; $display("FAIL edge_add_out: got %h expected 05", o); end
        n_cmp++; if (f !== 8'h82) begin n_fail++; $display("FAIL edge_add_flags: got %h expected 82", f); end
        n_cmp++; if (sticky_ovf !== 1'b0) begin n_fail++; $display("FAIL edge_add_sticky: got %b expected 0", sticky_ovf); end
        run_beat(8'h72, 8'h93, 4'h1, early, ov, o, f);
        n_cmp++; if (o !== 8'hDF) begin n_fail++; $display("FAIL edge_sub_out: got %h expected df", o); end
        n_cmp++; if (f !== 8'h9E) begin n_fail++; $display("FAIL edge_sub_flags: got %h expected 9e", f); end
        n_cmp++; if (sticky_ovf !== 1'b1) begin n_fail++; $display("FAIL edge_sub_sticky: got %b expected 1", sticky_ovf); end
    endtask

    task automatic test_shifts();
        logic early, ov;
        logic [7:0] o, f;
        logic [3:0]  ops  [6];
        logic [7:0]  eout [6];
        logic [7:0]  eflg [6];
        ops  = '{4'hC, 4'hA, 4'hB, 4'h9, 4'hD, 4'hE};
        eout = '{8'hF6, 8'h95, 8'h56, 8'h16, 8'h01, 8'h00};
        eflg = '{8'h48, 8'h48, 8'h40, 8'h50, 8'h50, 8'h41};
        for (int i = 0; i < 6; i++) begin
            run_beat(8'hB2, 8'h03, ops[i], early, ov, o, f);
            n_cmp++; if (o !== eout[i]) begin n_fail++; $display("FAIL shift_out op=%h: got %h expected %h", ops[i], o, eout[i]); end
            n_cmp++; if (f !== eflg[i]) begin n_fail++; $display("FAIL shift_flags op=%h: got %h expected %h", ops[i], f, eflg[i]); end
        end
        run_beat(8'hB2, 8'h08, 4'hA, early, ov, o, f);
        n_cmp++; if (o !== 8'hB2) begin n_fail++; $display("FAIL rol_wrap_zero: got %h expected b2", o); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_out [16];
        int tx, rx, cyc;
        logic [7:0] held;
        logic stall_ok, ir_low;
        exp_out = '{8'hB5, 8'hAF, 8'hFD, 8'h4C, 8'h02, 8'hB3, 8'hB1, 8'h4D,
                    8'h90, 8'h16, 8'h95, 8'h56, 8'hF6, 8'h01, 8'h00, 8'hB2};
        tx = 0; rx = 0; cyc = 0; held = 8'h00; stall_ok = 1'b1; ir_low = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        a = 8'hB2; b = 8'h03;
        while (rx < 16 && cyc < 100) begin
            @(negedge clk);
            out_ready = !(cyc >= 6 && cyc <= 8);
            in_valid  = (tx < 16);
            opcode    = tx[3:0];
            #1;
            if (cyc == 6) held = out;
            if (cyc >= 6 && cyc <= 8) begin
                if (!in_ready) ir_low = 1'b1;
                if (out !== held || out_valid !== 1'b1) stall_ok = 1'b0;
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (out !== exp_out[rx]) begin n_fail++; $display("FAIL stream_beat %0d: got %h expected %h", rx, out, exp_out[rx]); end
                rx++;
            end
            if (in_valid && in_ready) tx++;
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        n_cmp++; if (rx !== 16) begin n_fail++; $display("FAIL stream_count: got %0d expected 16", rx); end
        n_cmp++; if (ir_low !== 1'b1) begin n_fail++; $display("FAIL stall_in_ready: got %b expected 1", ir_low); end
        n_cmp++; if (stall_ok !== 1'b1) begin n_fail++; $display("FAIL stall_hold: got %b expected 1", stall_ok); end
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_no_extra: got %b expected 0", out_valid); end
    endtask

    task automatic test_sticky();
        @(negedge clk);
        clr_sticky = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (sticky_ovf !== 1'b0) begin n_fail++; $display("FAIL sticky_pre_clear: got %b expected 0", sticky_ovf); end
        @(negedge clk);
        clr_sticky = 1'b0;
        a = 8'h72; b = 8'h93; opcode = 4'h1; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; clr_sticky = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (sticky_ovf !== 1'b1) begin n_fail++; $display("FAIL sticky_set_wins: got %b expected 1", sticky_ovf); end
        @(negedge clk);
        clr_sticky = 1'b0;
        @(negedge clk);
        clr_sticky = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (sticky_ovf !== 1'b0) begin n_fail++; $display("FAIL sticky_clear_alone: got %b expected 0", sticky_ovf); end
        @(negedge clk);
        clr_sticky = 1'b0;
    endtask

    task automatic test_reset_midop();
        logic early, ov, stale;
        logic [7:0] o, f;
        @(negedge clk);
        a = 8'h11; b = 8'h22; opcode = 4'h0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a = 8'h33; b = 8'h01;
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL midop_inflight: got %b expected 1", out_valid); end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midop_rst_valid: got %b expected 0", out_valid); end
        n_cmp++; if (out !== 8'h00) begin n_fail++; $display("FAIL midop_rst_out: got %h expected 00", out); end
        @(negedge clk);
        rst_n = 1'b1;
        stale = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) stale = 1'b1;
        end
        n_cmp++; if (stale !== 1'b0) begin n_fail++; $display("FAIL midop_stale: got %b expected 0", stale); end
        run_beat(8'h40, 8'h02, 4'h8, early, ov, o, f);
        n_cmp++; if (early !== 1'b0 || ov !== 1'b1) begin n_fail++; $display("FAIL midop_latency: got early=%b valid=%b expected 0/1", early, ov); end
        n_cmp++; if (o !== 8'h00) begin n_fail++; $display("FAIL midop_next_out: got %h expected 00", o); end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr_sticky = 1'b0;
        a = 8'h00; b = 8'h00; opcode = 4'h0;
        test_reset();
        test_basic_add();
        test_add_sub_edge();
        test_shifts();
        test_back_to_back();
        test_sticky();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
